// File: rtl/axis_arb_pkg.sv
// Shared types and helpers for the packet round-robin AXI-Stream arbiter.
package axis_arb_pkg;

  typedef enum logic {IDLE, LOCK} arb_state_t;

  localparam int unsigned ARB_MAX_NUM = 16;

  // Reference round-robin pick: first asserted request after 'last', wrapping modulo 'num'.
  function automatic logic [3:0] rr_next(input logic [ARB_MAX_NUM-1:0] req,
                                         input logic [3:0]             last,
                                         input int unsigned            num);
    logic [3:0]  win;
    logic        found;
    int unsigned idx;
    win   = '0;
    found = 1'b0;
    for (int unsigned k = 1; k <= ARB_MAX_NUM; k++) begin
      idx = (32'(last) + k) % num;
      if (k <= num && !found && req[idx]) begin
        win   = 4'(idx);
        found = 1'b1;
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/rr_grant_select.sv
// Combinational round-robin selector: rotate requests past last_grant, priority-encode, unrotate.
module rr_grant_select #(
  parameter int unsigned NUM = 4,
  parameter int unsigned IDW = $clog2(NUM)
) (
  input  logic [NUM-1:0] req,
  input  logic [IDW-1:0] last_grant,
  output logic           any,
  output logic [IDW-1:0] winner
);

  logic [2*NUM-1:0] req2;
  logic [2*NUM-1:0] shifted;
  logic [NUM-1:0]   rot;
  logic             found;
  int unsigned      start;
  int unsigned      pos;
  int unsigned      sum;

  always_comb begin
    req2    = {req, req};
    start   = (32'(last_grant) + 32'd1) % NUM;
    shifted = req2 >> start;
    rot     = shifted[NUM-1:0];
    pos     = 0;
    found   = 1'b0;
    for (int unsigned i = 0; i < NUM; i++) begin
      if (!found && rot[i]) begin
        pos   = i;
        found = 1'b1;
      end
    end
    sum = start + pos;
    if (sum >= NUM) sum = sum - NUM;
    winner = IDW'(sum);
    any    = |req;
  end

endmodule

// File: rtl/axis_packet_rr_arbiter.sv
// Packet-granular round-robin arbiter sharing one AXI-Stream sink among NUM sources.
// Define AXIS_ARB_OUT_REG_EN to drive m_axis_* from the library's two-entry axis register slice.
module axis_packet_rr_arbiter
  import axis_arb_pkg::*;
#(
  parameter int unsigned NUM   = 4,
  parameter int unsigned DSIZE = 16,
  parameter int unsigned IDW   = $clog2(NUM)
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  input  logic                 aclken,
  input  logic [NUM*DSIZE-1:0] s_axis_tdata,
  input  logic [NUM-1:0]       s_axis_tvalid,
  input  logic [NUM-1:0]       s_axis_tlast,
  output logic [NUM-1:0]       s_axis_tready,
  output logic [DSIZE-1:0]     m_axis_tdata,
  output logic                 m_axis_tvalid,
  output logic                 m_axis_tlast,
  input  logic                 m_axis_tready,
  output logic [IDW-1:0]       grant_id,
  output logic                 busy
);

  arb_state_t       state_q;
  logic [IDW-1:0]   grant_id_q;
  logic [IDW-1:0]   last_grant_q;
  logic             busy_q;
  logic             any;
  logic [IDW-1:0]   winner;
  logic [DSIZE-1:0] arb_tdata;
  logic             arb_tvalid;
  logic             arb_tlast;
  logic             arb_tready;
  logic             xfer;

  rr_grant_select #(
    .NUM (NUM),
    .IDW (IDW)
  ) u_grant_select (
    .req        (s_axis_tvalid),
    .last_grant (last_grant_q),
    .any        (any),
    .winner     (winner)
  );

  always_comb begin
    arb_tdata     = '0;
    arb_tvalid    = 1'b0;
    arb_tlast     = 1'b0;
    s_axis_tready = '0;
    if (state_q == LOCK) begin
      for (int unsigned i = 0; i < NUM; i++) begin
        if (grant_id_q == IDW'(i)) begin
          arb_tdata        = s_axis_tdata[i*DSIZE +: DSIZE];
          arb_tvalid       = s_axis_tvalid[i];
          arb_tlast        = s_axis_tlast[i];
          s_axis_tready[i] = arb_tready & aclken;
        end
      end
    end
  end

  // Packet end is judged on the pre-output handshake so the skid option cannot shift it.
  assign xfer = arb_tvalid & arb_tready & aclken;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q      <= IDLE;
      grant_id_q   <= '0;
      last_grant_q <= IDW'(NUM - 1);
      busy_q       <= 1'b0;
    end else if (aclken) begin
      case (state_q)
        IDLE: begin
          if (any) begin
            grant_id_q <= winner;
            busy_q     <= 1'b1;
            state_q    <= LOCK;
          end
        end
        LOCK: begin
          if (xfer && arb_tlast) begin
            last_grant_q <= grant_id_q;
            busy_q       <= 1'b0;
            state_q      <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign grant_id = grant_id_q;
  assign busy     = busy_q;

`ifdef AXIS_ARB_OUT_REG_EN
  // tlast travels as the top bit of the slice payload.
  axis_register_slice #(
    .DATA_WIDTH (DSIZE + 1)
  ) u_out_slice (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .aclken        (aclken),
    .s_axis_tdata  ({arb_tlast, arb_tdata}),
    .s_axis_tvalid (arb_tvalid),
    .s_axis_tready (arb_tready),
    .m_axis_tdata  ({m_axis_tlast, m_axis_tdata}),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready)
  );
`else
  assign m_axis_tdata  = arb_tdata;
  assign m_axis_tvalid = arb_tvalid;
  assign m_axis_tlast  = arb_tlast;
  assign arb_tready    = m_axis_tready;
`endif

endmodule

// File: tb/tb_axis_packet_rr_arbiter.sv
// Randomized bench for axis_packet_rr_arbiter against a packet-owner model with per-port scoreboards.
module tb_axis_packet_rr_arbiter;

  localparam int NUM   = 4;
  localparam int DSIZE = 16;
  localparam int IDW   = 2;

  logic                 aclk = 1'b0;
  logic                 aresetn = 1'b0;
  logic                 aclken = 1'b0;
  logic [NUM*DSIZE-1:0] s_tdata = '0;
  logic [NUM-1:0]       s_tvalid = '0;
  logic [NUM-1:0]       s_tlast = '0;
  logic [NUM-1:0]       s_tready;
  logic [DSIZE-1:0]     m_tdata;
  logic                 m_tvalid;
  logic                 m_tlast;
  logic                 m_tready = 1'b0;
  logic [IDW-1:0]       gid;
  logic                 busy;

  always #5 aclk = ~aclk;

  axis_packet_rr_arbiter #(
    .NUM   (NUM),
    .DSIZE (DSIZE)
  ) dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .aclken        (aclken),
    .s_axis_tdata  (s_tdata),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tlast  (s_tlast),
    .s_axis_tready (s_tready),
    .m_axis_tdata  (m_tdata),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tlast  (m_tlast),
    .m_axis_tready (m_tready),
    .grant_id      (gid),
    .busy          (busy)
  );

  int n_total = 0;
  int n_pass  = 0;

  // Source-side pending beats ({last,data}) and sink-side expected beats, per port.
  logic [DSIZE:0] bfm_q[NUM][$];
  logic [DSIZE:0] exp_q[NUM][$];

  // Model: which port owns the output (-1 = none), who won last, what grant_id shows.
  int owner = -1;
  int lastg = NUM - 1;
  int mgid  = 0;

  int vprob = 100;
  int rprob = 100;
  int enprob = 100;
  bit force_en_low = 1'b0;

  int cyc = 0;
  int grant_log[$];
  int in_beats = 0;
  int out_beats = 0;
  int xfer_cnt = 0;
  int first_xfer = -1;
  int last_xfer = -1;
  int rdy0_while1 = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s cyc=%0d got=%0h exp=%0h", nm, cyc, act, exp);
  endtask

  function automatic bit all_idle();
    bit r;
    r = (owner < 0);
    for (int p = 0; p < NUM; p++)
      if (bfm_q[p].size() != 0 || exp_q[p].size() != 0) r = 1'b0;
    return r;
  endfunction

  task automatic add_pkt(input int p, input int len, input int base);
    logic [DSIZE:0] b;
    for (int i = 0; i < len; i++) begin
      b[DSIZE-1:0] = (base >= 0) ? DSIZE'(base + i) : DSIZE'($urandom);
      b[DSIZE]     = (i == len - 1);
      bfm_q[p].push_back(b);
      exp_q[p].push_back(b);
      in_beats++;
    end
  endtask

  task automatic cycle(input bit rst);
    logic [DSIZE:0]   b;
    logic [NUM-1:0]   exp_rdy;
    logic [DSIZE-1:0] exp_data;
    logic             exp_v;
    logic             exp_l;
    bit               found;
    int               idx;
    @(negedge aclk);
    for (int p = 0; p < NUM; p++) begin
      if (bfm_q[p].size() > 0) begin
        b = bfm_q[p][0];
        s_tvalid[p] = (int'($urandom_range(99)) < vprob);
        s_tdata[p*DSIZE +: DSIZE] = b[DSIZE-1:0];
        s_tlast[p] = b[DSIZE];
      end else begin
        s_tvalid[p] = 1'b0;
        s_tdata[p*DSIZE +: DSIZE] = DSIZE'($urandom);
        s_tlast[p] = 1'b0;
      end
    end
    m_tready = (int'($urandom_range(99)) < rprob);
    aclken   = force_en_low ? 1'b0 : (int'($urandom_range(99)) < enprob);
    if (rst) begin
      aresetn = 1'b0;
      for (int p = 0; p < NUM; p++) begin
        bfm_q[p].delete();
        exp_q[p].delete();
      end
      owner = -1;
      lastg = NUM - 1;
      mgid  = 0;
      grant_log.delete();
    end else begin
      aresetn = 1'b1;
    end
    #1;
    exp_v = 1'b0; exp_l = 1'b0; exp_data = '0; exp_rdy = '0;
    if (owner >= 0) begin
      exp_v    = s_tvalid[owner];
      exp_l    = s_tlast[owner];
      exp_data = s_tdata[owner*DSIZE +: DSIZE];
      exp_rdy[owner] = m_tready & aclken;
    end
    chk("m_tvalid", 64'(m_tvalid), 64'(exp_v));
    chk("m_tlast",  64'(m_tlast),  64'(exp_l));
    chk("m_tdata",  64'(m_tdata),  64'(exp_data));
    chk("s_tready", 64'(s_tready), 64'(exp_rdy));
    chk("grant_id", 64'(gid),      64'(mgid));
    chk("busy",     64'(busy),     64'(owner >= 0));
    if (aresetn) begin
      if (owner == 1 && s_tready[0]) rdy0_while1++;
      for (int p = 0; p < NUM; p++)
        if (s_tready[p] && s_tvalid[p] && aclken && bfm_q[p].size() > 0)
          void'(bfm_q[p].pop_front());
      if (m_tvalid && m_tready && aclken) begin
        out_beats++;
        xfer_cnt++;
        if (first_xfer < 0) first_xfer = cyc;
        last_xfer = cyc;
        if (owner < 0 || exp_q[owner < 0 ? 0 : owner].size() == 0) begin
          chk("stray_beat", 64'(m_tvalid), 64'(0));
        end else begin
          b = exp_q[owner].pop_front();
          chk("beat", 64'({m_tlast, m_tdata}), 64'(b));
        end
      end
      if (aclken) begin
        if (owner < 0) begin
          found = 1'b0;
          for (int k = 1; k <= NUM; k++) begin
            idx = (lastg + k) % NUM;
            if (!found && s_tvalid[idx]) begin
              found = 1'b1;
              owner = idx;
              mgid  = idx;
              grant_log.push_back(idx);
            end
          end
        end else if (s_tvalid[owner] && m_tready && s_tlast[owner]) begin
          lastg = owner;
          owner = -1;
        end
      end
    end
    cyc++;
  endtask

  task automatic do_reset();
    cycle(1'b1);
    chk("rst_m_tvalid", 64'(m_tvalid), 64'(0));
    chk("rst_m_tlast",  64'(m_tlast),  64'(0));
    chk("rst_m_tdata",  64'(m_tdata),  64'(0));
    chk("rst_s_tready", 64'(s_tready), 64'(0));
    chk("rst_grant_id", 64'(gid),      64'(0));
    chk("rst_busy",     64'(busy),     64'(0));
    cycle(1'b1);
  endtask

  task automatic run_until_empty(input int budget);
    int left;
    for (int i = 0; i < budget && !all_idle(); i++) cycle(1'b0);
    left = 0;
    for (int p = 0; p < NUM; p++) left += exp_q[p].size();
    chk("drain_left_beats", 64'(left), 64'(0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    int exp_order[8];

    // Lone port 2, 4 beats A0..A3, full ready.
    do_reset();
    add_pkt(2, 4, 'hA0);
    c0 = cyc; first_xfer = -1; xfer_cnt = 0;
    run_until_empty(50);
    chk("t1_grant_n", 64'(grant_log.size()), 64'(1));
    if (grant_log.size() > 0) chk("t1_grant", 64'(grant_log[0]), 64'(2));
    chk("t1_first_lat", 64'(first_xfer - c0), 64'(1));
    chk("t1_last_lat",  64'(last_xfer - c0),  64'(4));
    chk("t1_xfers",     64'(xfer_cnt),        64'(4));
    cycle(1'b0);
    chk("t1_busy_after", 64'(busy), 64'(0));
    chk("t1_gid_held",   64'(gid),  64'(2));

    // All ports, two 2-beat packets each: strict rotation with one bubble per packet.
    do_reset();
    for (int r = 0; r < 2; r++)
      for (int p = 0; p < NUM; p++) add_pkt(p, 2, (p << 8) + (r << 4));
    c0 = cyc;
    run_until_empty(100);
    exp_order = '{0, 1, 2, 3, 0, 1, 2, 3};
    chk("t2_grant_n", 64'(grant_log.size()), 64'(8));
    for (int i = 0; i < 8 && i < grant_log.size(); i++)
      chk("t2_grant_order", 64'(grant_log[i]), 64'(exp_order[i]));
    chk("t2_cycles", 64'(cyc - c0), 64'(24));

    // Port 0 arrives while port 1 is mid-packet: no preemption.
    do_reset();
    add_pkt(1, 5, 'h100);
    for (int i = 0; i < 20 && bfm_q[1].size() > 3; i++) cycle(1'b0);
    add_pkt(0, 2, 'h200);
    rdy0_while1 = 0;
    run_until_empty(50);
    chk("t3_grant_n", 64'(grant_log.size()), 64'(2));
    if (grant_log.size() > 1) begin
      chk("t3_first", 64'(grant_log[0]), 64'(1));
      chk("t3_second", 64'(grant_log[1]), 64'(0));
    end
    chk("t3_rdy0_during_p1", 64'(rdy0_while1), 64'(0));

    // Random traffic: 200 packets, 70% valid, 50% ready, occasional clock-enable drops.
    vprob = 70; rprob = 50; enprob = 90;
    in_beats = 0; out_beats = 0;
    for (int i = 0; i < 200; i++)
      add_pkt(int'($urandom_range(NUM - 1)), int'($urandom_range(6, 1)), -1);
    run_until_empty(20000);
    chk("t4_beats", 64'(out_beats), 64'(in_beats));
    vprob = 100; rprob = 100; enprob = 100;

    // Reset during beat 3 of port 3, then port 0 must win first.
    do_reset();
    add_pkt(3, 6, 'h300);
    for (int i = 0; i < 20 && bfm_q[3].size() > 4; i++) cycle(1'b0);
    cycle(1'b1);
    chk("t5_tvalid_0", 64'(m_tvalid), 64'(0));
    chk("t5_tdata_0",  64'(m_tdata),  64'(0));
    chk("t5_tready_0", 64'(s_tready), 64'(0));
    chk("t5_busy_0",   64'(busy),     64'(0));
    cycle(1'b1);
    add_pkt(3, 2, 'h380);
    add_pkt(0, 2, 'h080);
    run_until_empty(50);
    chk("t5_grant_n", 64'(grant_log.size()), 64'(2));
    if (grant_log.size() > 1) begin
      chk("t5_first", 64'(grant_log[0]), 64'(0));
      chk("t5_second", 64'(grant_log[1]), 64'(3));
    end

    // aclken low for 5 cycles mid-packet freezes the transfer.
    do_reset();
    add_pkt(2, 4, 'h400);
    for (int i = 0; i < 20 && bfm_q[2].size() > 3; i++) cycle(1'b0);
    force_en_low = 1'b1;
    xfer_cnt = 0;
    for (int i = 0; i < 5; i++) cycle(1'b0);
    chk("t6_no_xfer", 64'(xfer_cnt), 64'(0));
    chk("t6_gid",     64'(gid),      64'(2));
    chk("t6_busy",    64'(busy),     64'(1));
    force_en_low = 1'b0;
    run_until_empty(50);
    chk("t6_rest", 64'(xfer_cnt), 64'(3));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
